// File: rtl/uwb_tx_scheduler_pkg.sv
// uwb_sched_pkg: shared types and constants for the UWB transmit scheduler.
// TX_PREAMBLE_EN adds the PREAMBLE state.
package uwb_sched_pkg;
    typedef enum logic [1:0] {
        IDLE,
`ifdef TX_PREAMBLE_EN
        PREAMBLE,
`endif
        DATA,
        GAP
    } state_t;
    localparam logic [7:0] PREAMBLE_PATTERN = 8'hA5;
    localparam int PREAMBLE_W = 8;
endpackage

// File: rtl/uwb_tx_scheduler_if.sv
// uwb_tx_if: requester handshakes plus serial bit stream of the transmit scheduler.
interface uwb_tx_if #(parameter int DATA_W = 128);
    logic              req0_valid, req1_valid;
    logic [DATA_W-1:0] req0_data, req1_data;
    logic              req0_ready, req1_ready;
    logic              bit_out, bit_valid, bit_last, frame_start, grant_id, busy;
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data,
        input  req0_ready, req1_ready, bit_out, bit_valid, bit_last, frame_start, grant_id, busy
    );
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data,
        output req0_ready, req1_ready, bit_out, bit_valid, bit_last, frame_start, grant_id, busy
    );
endinterface

// File: rtl/uwb_rr_arbiter.sv
// uwb_rr_arbiter: 2-way round-robin arbiter, one-hot grant, favours the requester not served last.
module uwb_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_served,
    input  logic       enable,
    output logic [1:0] grant
);
    // A lone requester wins outright; on contention the pointer picks the other one.
    always_comb begin
        grant = !enable ? 2'b00 : valid == 2'b11 ? (last_served ? 2'b01 : 2'b10) : valid;
    end
endmodule

// File: rtl/uwb_tx_scheduler.sv
// uwb_tx_scheduler: shares the UWB serial bit path between two frame requesters, MSB-first.
// Defining TX_PREAMBLE_EN prefixes every frame with PREAMBLE_PATTERN.
module uwb_tx_scheduler
    import uwb_sched_pkg::*;
#(
    parameter int DATA_W     = 128,
    parameter int BIT_CYCLES = 16,
    parameter int GAP_CYCLES = 4
) (
    input logic     clk,
    input logic     rst,
    uwb_tx_if.slave bus
);
    localparam int CW = $clog2(BIT_CYCLES) + 1;
    localparam int IW = $clog2(DATA_W);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef TX_PREAMBLE_EN
    localparam state_t FIRST = PREAMBLE;
`else
    localparam state_t FIRST = DATA;
`endif

    state_t            state, state_n;
    logic [CW-1:0]     cyc;
    logic [IW-1:0]     idx;
    logic [GW-1:0]     gcnt;
    logic [DATA_W-1:0] sreg;
    logic              last_served, grant_id, frame_start;
    logic              sending, bit_end, frame_end, pre_end, gap_end, pre_bit;
    logic [1:0]        grant;

    // Ready is forced low while reset is held so every output reads 0 in reset.
    uwb_rr_arbiter u_arb (
        .valid       ({bus.req1_valid, bus.req0_valid}),
        .last_served (last_served),
        .enable      (state == IDLE && !rst),
        .grant       (grant)
    );

    // Bit-period boundary and terminal counts of preamble, frame and gap.
    always_comb begin
        bit_end   = cyc == CW'(BIT_CYCLES - 1);
        frame_end = state == DATA && bit_end && idx == IW'(DATA_W - 1);
        gap_end   = state == GAP && gcnt == GW'(GAP_CYCLES - 1);
`ifdef TX_PREAMBLE_EN
        pre_end   = state == PREAMBLE && bit_end && idx == IW'(PREAMBLE_W - 1);
        pre_bit   = state == PREAMBLE && PREAMBLE_PATTERN[~idx[2:0]];
        sending   = state == PREAMBLE || state == DATA;
`else
        pre_end   = 1'b0;
        pre_bit   = 1'b0;
        sending   = state == DATA;
`endif
    end

    // Next state: IDLE -> (PREAMBLE) -> DATA -> (GAP) -> IDLE.
    always_comb begin
        state_n = state;
        if (state == IDLE && |grant) state_n = FIRST;
        if (pre_end) state_n = DATA;
        if (frame_end) state_n = GAP_CYCLES == 0 ? IDLE : GAP;
        if (gap_end) state_n = IDLE;
    end

    // State, counters, latched frame and arbitration pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cyc         <= '0;
            idx         <= '0;
            gcnt        <= '0;
            sreg        <= '0;
            last_served <= 1'b1;
            grant_id    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            frame_start <= |grant;
            if (|grant) begin
                sreg        <= grant[1] ? bus.req1_data : bus.req0_data;
                grant_id    <= grant[1];
                last_served <= grant[1];
            end else if (state == DATA && bit_end) begin
                sreg <= sreg << 1;
            end
            cyc  <= sending && !bit_end ? cyc + 1'b1 : '0;
            idx  <= !sending || !bit_end ? idx : (pre_end || frame_end) ? '0 : idx + 1'b1;
            gcnt <= state == GAP && !gap_end ? gcnt + 1'b1 : '0;
        end
    end

    assign bus.req0_ready  = grant[0];
    assign bus.req1_ready  = grant[1];
    assign bus.bit_valid   = sending;
    assign bus.bit_out     = (state == DATA && sreg[DATA_W-1]) || pre_bit;
    assign bus.bit_last    = state == DATA && idx == IW'(DATA_W - 1);
    assign bus.busy        = state != IDLE;
    assign bus.frame_start = frame_start;
    assign bus.grant_id    = grant_id;
endmodule

// File: doc/uwb_tx_scheduler.md
# uwb_tx_scheduler

Frame scheduler that shares the UWB serial transmit path between two 128-bit frame requesters. It arbitrates round-robin, latches the winning frame and serializes it MSB-first at a fixed symbol rate. The serialized bit and its strobe feed the UWB transmitter's bit input, replacing a free-running buffer with a sequenced, handshaked source. An optional preamble can precede each frame, and a programmable idle gap follows it.

## Interface
- DATA_W, 128: frame width in bits.
- BIT_CYCLES, 16: clocks per transmitted bit; must be ≥ 1.
- GAP_CYCLES, 4: idle clocks after each frame; 0 allowed.
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid / req1_valid  input  1  requester has a frame.
- req0_data / req1_data  input  DATA_W  frame content.
- req0_ready / req1_ready  output  1  frame accepted this cycle when ANDed with valid.
- bit_out  output  1  current serial bit to the transmitter.
- bit_valid  output  1  high while bit_out carries a frame or preamble bit.
- bit_last  output  1  high during the final bit period of a frame.
- frame_start  output  1  one-cycle pulse on the first clock of a frame.
- grant_id  output  1  requester that owns the current or last frame.
- busy  output  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, PREAMBLE, DATA, GAP.
- IDLE: the arbiter evaluates the valid inputs. If only one is valid, that requester is granted. If both are valid, the requester not served last is granted. Exactly one ready is driven high, combinationally, in IDLE only. A transfer occurs when valid and ready are both high.
- On transfer: the data is latched into the shift register, grant_id is updated, and last_served is updated.
  - With the preamble enabled, the next state is PREAMBLE.
  - Otherwise the next state is DATA.
- PREAMBLE: sends the 8 bits of 8'hA5, MSB first, BIT_CYCLES clocks each, then goes to DATA.
- DATA: shifts out DATA_W bits, MSB first, BIT_CYCLES clocks each. bit_last is high for the whole last bit period.
- GAP: bit_valid is 0 and bit_out is 0. The block holds GAP_CYCLES clocks, then returns to IDLE. When GAP_CYCLES is 0, the block goes from the last bit directly to IDLE.
- The requester must hold valid and data stable until accepted. If a requester drops valid before acceptance, no frame is taken and no error is flagged.
- Later input changes do not affect a frame once it is latched.
- Counters:
  - Bit-period counter is $clog2(BIT_CYCLES)+1 bits wide and counts 0..BIT_CYCLES-1.
  - Bit index counter is wide enough for DATA_W-1.
  - Gap counter is wide enough for GAP_CYCLES.
  - No counter wraps outside its terminal count.

## Timing
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Shift register is 0.
  - last_served is 1, so req0 wins the first contention.
- Transfer on cycle T:
  - frame_start is high and bit_valid first goes high at T+1.
  - bit_out carries the first bit (preamble or data MSB) from T+1.
- Frame length is (DATA_W + 8·P) · BIT_CYCLES clocks, where P = 1 if the preamble is compiled in, otherwise 0.
- The next handshake is possible at the earliest GAP_CYCLES clocks after the last bit period ends, in the first IDLE cycle.
- BIT_CYCLES = 1: bit_out changes every clock, and bit_valid stays continuously high across the frame.
- Reset asserted mid-frame:
  - All outputs go to 0 immediately (asynchronously).
  - The frame is discarded and not resumed.
  - The arbiter pointer resets.

## Configuration
- TX_PREAMBLE_EN defined: the PREAMBLE state is present, and every frame is prefixed with 8'hA5.
- TX_PREAMBLE_EN undefined: the PREAMBLE state and its logic are removed, and transfer goes directly to DATA.

## Structure
- Package uwb_sched_pkg contains:
  - state enum type;
  - PREAMBLE_PATTERN = 8'hA5;
  - PREAMBLE_W = 8.
- Sub-module uwb_rr_arbiter: a 2-way round-robin arbiter with inputs valid[1:0], last_served and enable, producing a one-hot grant. It is instantiated once.

## Test plan
- Single frame, preamble off, BIT_CYCLES=2: req0 sends 128'h8000…0001.
  - bit_valid is high for 256 clocks starting at T+1.
  - bit_out is 1 for the first 2 clocks, 0 for the middle clocks, and 1 for the last 2 clocks.
  - bit_last is high for the last 2 clocks.
- Contention: both requesters are valid continuously from reset.
  - Grants alternate 0, 1, 0, 1.
  - grant_id matches, and each frame's bits equal its requester's data.
- Preamble on, BIT_CYCLES=1:
  - The first 8 bits are 1,0,1,0,0,1,0,1.
  - The data MSB follows at T+9.
  - frame_start is a single pulse at T+1.
- Gap check, GAP_CYCLES=4, req1 held valid:
  - The next ready is high exactly 4 clocks after bit_last falls.
  - With GAP_CYCLES=0, it is high on the next clock.
- Reset mid-DATA at bit 50: all outputs are 0 within the same cycle. After release, req0 (not req1) wins the first contention.
- Input change after acceptance: req0_data is altered at T+1. The serialized bits equal the value latched at T.
